// File: rtl/countdown_timer_ms.sv
// rtl/countdown_timer_ms.sv - millisecond countdown timer with one-cycle done pulse
// Optional periodic mode under `define AUTO_RELOAD_EN.
module countdown_timer_ms #(
  parameter int CLOCK_SPEED = 25000000,
  parameter int MS_WIDTH    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [MS_WIDTH-1:0] load_ms,
  input  logic                pause,
  input  logic                cancel,
  output logic                busy,
  output logic                done,
  output logic [MS_WIDTH-1:0] remaining_ms
);

  localparam int CYCLES_PER_MS = CLOCK_SPEED / 1000;
  localparam int PS_W          = $clog2(CYCLES_PER_MS);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CYCLES_PER_MS - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;

  logic [1:0]      state;
  logic [PS_W-1:0] prescaler;
`ifdef AUTO_RELOAD_EN
  logic [MS_WIDTH-1:0] period;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      remaining_ms <= '0;
      prescaler    <= '0;
`ifdef AUTO_RELOAD_EN
      period       <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (cancel) begin
        state        <= ST_IDLE;
        busy         <= 1'b0;
        remaining_ms <= '0;
        prescaler    <= '0;
      end else if (start) begin
        prescaler <= '0;
        if (load_ms != '0) begin
          state        <= ST_RUN;
          busy         <= 1'b1;
          remaining_ms <= load_ms;
`ifdef AUTO_RELOAD_EN
          period       <= load_ms;
`endif
        end else begin
          // zero-length request expires immediately
          state        <= ST_IDLE;
          busy         <= 1'b0;
          done         <= 1'b1;
          remaining_ms <= '0;
        end
      end else if (state != ST_IDLE) begin
        if (pause) begin
          state <= ST_PAUSED;
        end else begin
          // the resume edge itself counts, so a P-cycle pause delays done by P
          state <= ST_RUN;
          if (prescaler == PS_LAST) begin
            prescaler <= '0;
            if (remaining_ms <= MS_WIDTH'(1)) begin
              done <= 1'b1;
`ifdef AUTO_RELOAD_EN
              remaining_ms <= period;
`else
              state        <= ST_IDLE;
              busy         <= 1'b0;
              remaining_ms <= '0;
`endif
            end else begin
              remaining_ms <= remaining_ms - MS_WIDTH'(1);
            end
          end else begin
            prescaler <= prescaler + PS_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer_ms.sv
// tb/tb_countdown_timer_ms.sv - directed self-checking bench for countdown_timer_ms
module tb_countdown_timer_ms;

  localparam int MS_WIDTH = 16;

  logic                clk;
  logic                rst;
  logic                start;
  logic [MS_WIDTH-1:0] load_ms;
  logic                pause;
  logic                cancel;
  logic                busy;
  logic                done;
  logic [MS_WIDTH-1:0] remaining_ms;

  int checks;
  int errors;

  countdown_timer_ms #(.CLOCK_SPEED(10000), .MS_WIDTH(MS_WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .load_ms(load_ms),
    .pause(pause),
    .cancel(cancel),
    .busy(busy),
    .done(done),
    .remaining_ms(remaining_ms)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // edge 0: start sampled with the given load
  task automatic kick(input int n);
    start   = 1'b1;
    load_ms = MS_WIDTH'(n);
    tick();
    start   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; load_ms = 16'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({busy, done, remaining_ms} !== {1'b0, 1'b0, 16'd0}) begin
        errors++;
        $display("FAIL reset cyc%0d: busy=%b done=%b rem=%0d, want 0/0/0", i, busy, done, remaining_ms);
      end
    end
    start = 1'b0; rst = 1'b1;
    tick();
  endtask

  task automatic test_countdown();
    logic [17:0] exp;
    kick(3);
    checks++;
    if ({busy, done, remaining_ms} !== {1'b1, 1'b0, 16'd3}) begin
      errors++;
      $display("FAIL count edge0: busy=%b done=%b rem=%0d, want 1/0/3", busy, done, remaining_ms);
    end
    for (int k = 1; k <= 34; k++) begin
      tick();
      exp = {k < 30, k == 30, (k < 30) ? 16'(3 - k / 10) : 16'd0};
      checks++;
      if ({busy, done, remaining_ms} !== exp) begin
        errors++;
        $display("FAIL count edge%0d: got %h want %h", k, {busy, done, remaining_ms}, exp);
      end
    end
  endtask

  task automatic test_pause();
    logic [17:0] exp;
    kick(3);
    for (int k = 1; k <= 40; k++) begin
      pause = (k >= 12 && k <= 18);
      tick();
      exp = {k < 37, k == 37, (k < 10) ? 16'd3 : (k < 27) ? 16'd2 : (k < 37) ? 16'd1 : 16'd0};
      checks++;
      if ({busy, done, remaining_ms} !== exp) begin
        errors++;
        $display("FAIL pause edge%0d: got %h want %h", k, {busy, done, remaining_ms}, exp);
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_cancel();
    logic [17:0] exp;
    kick(3);
    for (int k = 1; k <= 40; k++) begin
      cancel = (k == 15);
      tick();
      exp = {k < 15, 1'b0, (k >= 15) ? 16'd0 : (k < 10) ? 16'd3 : 16'd2};
      checks++;
      if ({busy, done, remaining_ms} !== exp) begin
        errors++;
        $display("FAIL cancel edge%0d: got %h want %h", k, {busy, done, remaining_ms}, exp);
      end
    end
    cancel = 1'b0;
  endtask

  task automatic test_zero_load();
    kick(0);
    checks++;
    if ({busy, done, remaining_ms} !== {1'b0, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL zero edge0: busy=%b done=%b rem=%0d, want 0/1/0", busy, done, remaining_ms);
    end
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL zero edge1: busy=%b done=%b, want 0/0", busy, done);
    end
  endtask

  task automatic test_restart();
    logic [17:0] exp;
    kick(3);
    for (int k = 1; k <= 50; k++) begin
      start   = (k == 25);
      load_ms = 16'd2;
      tick();
      if (k < 25)
        exp = {1'b1, 1'b0, 16'(3 - k / 10)};
      else
        exp = {k < 45, k == 45, (k < 35) ? 16'd2 : (k < 45) ? 16'd1 : 16'd0};
      checks++;
      if ({busy, done, remaining_ms} !== exp) begin
        errors++;
        $display("FAIL restart edge%0d: got %h want %h", k, {busy, done, remaining_ms}, exp);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_idle_pause_and_midrun_reset();
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({busy, done, remaining_ms} !== {1'b0, 1'b0, 16'd0}) begin
        errors++;
        $display("FAIL idle_pause cyc%0d: got %h want 0", i, {busy, done, remaining_ms});
      end
    end
    pause = 1'b0;
    kick(3);
    for (int k = 1; k <= 40; k++) begin
      rst = (k != 12);
      tick();
      checks++;
      if (k >= 12 && {busy, done, remaining_ms} !== {1'b0, 1'b0, 16'd0}) begin
        errors++;
        $display("FAIL midrun_reset edge%0d: got %h want 0", k, {busy, done, remaining_ms});
      end else if (k < 12 && busy !== 1'b1) begin
        errors++;
        $display("FAIL midrun_reset edge%0d: busy=%b want 1", k, busy);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_back_to_back();
    kick(1);
    for (int k = 1; k <= 21; k++) begin
      start   = (k == 11);
      load_ms = 16'd1;
      tick();
      checks++;
      if (done !== (k == 10 || k == 21)) begin
        errors++;
        $display("FAIL b2b edge%0d: done=%b want %b", k, done, (k == 10 || k == 21));
      end
    end
    start = 1'b0;
    tick();
  endtask

`ifdef AUTO_RELOAD_EN
  task automatic test_auto_reload();
    kick(2);
    for (int k = 1; k <= 90; k++) begin
      cancel = (k == 65);
      tick();
      checks++;
      if ({busy, done} !== {k < 65, k == 20 || k == 40 || k == 60}) begin
        errors++;
        $display("FAIL reload edge%0d: busy=%b done=%b", k, busy, done);
      end
    end
    cancel = 1'b0;
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; start = 1'b0; load_ms = '0; pause = 1'b0; cancel = 1'b0;
    test_reset();
`ifdef AUTO_RELOAD_EN
    test_auto_reload();
`else
    test_countdown();
    test_pause();
    test_cancel();
    test_zero_load();
    test_restart();
    test_idle_pause_and_midrun_reset();
    test_back_to_back();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
